// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the hazard controller and the pipeline datapath.
// The slave modport is the controller side; the master modport is the datapath side.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       rs_id;
    logic [4:0]       rt_id;
    logic             uses_rs_id;
    logic             uses_rt_id;
    logic             MemRead_ex;
    logic             RegWrite_ex;
    logic [4:0]       Wreg_addr_ex;
    logic             PCSrc_ex;
    logic             dmem_req;
    logic             dmem_ready;
    logic             PC_write;
    logic             IFID_write;
    logic             IFID_flush;
    logic             IDEX_bubble;
    logic             pipe_freeze;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [1:0]       hz_state;

    modport slave (
        input  rs_id, rt_id, uses_rs_id, uses_rt_id, MemRead_ex, RegWrite_ex,
        input  Wreg_addr_ex, PCSrc_ex, dmem_req, dmem_ready,
        output PC_write, IFID_write, IFID_flush, IDEX_bubble, pipe_freeze,
        output stall_cnt, flush_cnt, hz_state
    );

    modport master (
        output rs_id, rt_id, uses_rs_id, uses_rt_id, MemRead_ex, RegWrite_ex,
        output Wreg_addr_ex, PCSrc_ex, dmem_req, dmem_ready,
        input  PC_write, IFID_write, IFID_flush, IDEX_bubble, pipe_freeze,
        input  stall_cnt, flush_cnt, hz_state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the ID/EX register and its neighbours.
// Detects load-use hazards, flushes wrong-path work on EX-resolved branches,
// freezes the pipe on data-memory wait states and keeps saturating debug counters.
// Control outputs are combinational so they settle before the negedge that
// loads the pipeline registers. LOAD_STALL_CYCLES must lie in 1..3.
module pipe_hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    pipe_hazard_ctrl_if.slave        hz_if
);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StLstall = 2'd1,
        StMwait  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CntMax      = '1;
    localparam logic [1:0]       LoadCntInit = 2'(LOAD_STALL_CYCLES - 1);

    state_e           state_q, state_d;
    state_e           ret_q, ret_d;     // state to resume once the memory wait ends
    logic [1:0]       lcnt_q, lcnt_d;   // remaining LSTALL bubbles
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic   hz;
    logic   fz;
    state_e eff_st;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CntMax) ? v : v + CNT_W'(1);
    endfunction

    // Hazard and freeze detection.
    always_comb begin
        hz = hz_if.MemRead_ex && hz_if.RegWrite_ex && (hz_if.Wreg_addr_ex != 5'd0) &&
             ((hz_if.uses_rs_id && (hz_if.rs_id == hz_if.Wreg_addr_ex)) ||
              (hz_if.uses_rt_id && (hz_if.rt_id == hz_if.Wreg_addr_ex)));
        fz = hz_if.dmem_req && !hz_if.dmem_ready;
        // On the release cycle of a memory wait, the resumed state governs behaviour.
        eff_st = (state_q == StMwait) ? ret_q : state_q;
    end

    // Pipeline control outputs, priority freeze > branch flush > stall > normal.
    always_comb begin
        hz_if.PC_write    = 1'b1;
        hz_if.IFID_write  = 1'b1;
        hz_if.IFID_flush  = 1'b0;
        hz_if.IDEX_bubble = 1'b0;
        hz_if.pipe_freeze = 1'b0;
        if (!RST_N) begin
            // Drive NOPs into the unreset pipeline registers while held in reset.
            hz_if.PC_write    = 1'b0;
            hz_if.IFID_write  = 1'b0;
            hz_if.IFID_flush  = 1'b1;
            hz_if.IDEX_bubble = 1'b1;
        end else if (fz) begin
            hz_if.PC_write    = 1'b0;
            hz_if.IFID_write  = 1'b0;
            hz_if.pipe_freeze = 1'b1;
        end else if (hz_if.PCSrc_ex) begin
            hz_if.IFID_flush  = 1'b1;
            hz_if.IDEX_bubble = 1'b1;
        end else if ((eff_st == StRun && hz) || eff_st == StLstall) begin
            hz_if.PC_write    = 1'b0;
            hz_if.IFID_write  = 1'b0;
            hz_if.IDEX_bubble = 1'b1;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        lcnt_d      = lcnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (fz) begin
            // Frozen cycles hold everything; only remember where to come back to.
            if (state_q != StMwait) begin
                ret_d   = state_q;
                state_d = StMwait;
            end
        end else begin
            state_d = eff_st;
            if (hz_if.PCSrc_ex) begin
                state_d     = StRun;
                flush_cnt_d = sat_inc(flush_cnt_q);
            end else if (eff_st == StLstall) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
                lcnt_d      = lcnt_q - 2'd1;
                if (lcnt_q == 2'd1) begin
                    state_d = StRun;
                end
            end else if (hz) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
                if (LOAD_STALL_CYCLES > 1) begin
                    state_d = StLstall;
                    lcnt_d  = LoadCntInit;
                end
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StRun;
            ret_q       <= StRun;
            lcnt_q      <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            lcnt_q      <= lcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz_if.stall_cnt = stall_cnt_q;
    assign hz_if.flush_cnt = flush_cnt_q;
    assign hz_if.hz_state  = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: three instances with different stall depths
// and counter widths, expectations queued per step and compared off the clock edge.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    typedef struct {
        string       tag;
        int          id;
        logic [4:0]  ctl;   // {PC_write, IFID_write, IFID_flush, IDEX_bubble, pipe_freeze}
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t sb_q[$];

    localparam logic [4:0] CtlNorm  = 5'b11000;
    localparam logic [4:0] CtlStall = 5'b00010;
    localparam logic [4:0] CtlFlush = 5'b11110;
    localparam logic [4:0] CtlFrz   = 5'b00001;
    localparam logic [4:0] CtlRst   = 5'b00110;

    pipe_hazard_ctrl_if #(.CNT_W(16)) if1 ();
    pipe_hazard_ctrl_if #(.CNT_W(16)) if2 ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  if3 ();

    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .hz_if(if1.slave)
    );
    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(2), .CNT_W(16)) u_dut2 (
        .CLK(clk), .RST_N(rst_n), .hz_if(if2.slave)
    );
    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) u_dut3 (
        .CLK(clk), .RST_N(rst_n), .hz_if(if3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input int id, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic mr, input logic rw,
                         input logic [4:0] wa, input logic pcs, input logic req,
                         input logic rdy);
        case (id)
            1: begin
                if1.rs_id = rs; if1.rt_id = rt; if1.uses_rs_id = urs; if1.uses_rt_id = urt;
                if1.MemRead_ex = mr; if1.RegWrite_ex = rw; if1.Wreg_addr_ex = wa;
                if1.PCSrc_ex = pcs; if1.dmem_req = req; if1.dmem_ready = rdy;
            end
            2: begin
                if2.rs_id = rs; if2.rt_id = rt; if2.uses_rs_id = urs; if2.uses_rt_id = urt;
                if2.MemRead_ex = mr; if2.RegWrite_ex = rw; if2.Wreg_addr_ex = wa;
                if2.PCSrc_ex = pcs; if2.dmem_req = req; if2.dmem_ready = rdy;
            end
            default: begin
                if3.rs_id = rs; if3.rt_id = rt; if3.uses_rs_id = urs; if3.uses_rt_id = urt;
                if3.MemRead_ex = mr; if3.RegWrite_ex = rw; if3.Wreg_addr_ex = wa;
                if3.PCSrc_ex = pcs; if3.dmem_req = req; if3.dmem_ready = rdy;
            end
        endcase
    endtask

    task automatic idle(input int id);
        drive(id, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic hazard(input int id);
        drive(id, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input int id, input string tag, input logic [4:0] ctl,
                        input logic [1:0] st, input logic [15:0] sc, input logic [15:0] fc);
        exp_t e;
        e.id = id; e.tag = tag; e.ctl = ctl; e.st = st; e.sc = sc; e.fc = fc;
        sb_q.push_back(e);
    endtask

    task automatic push_all(input string tag, input logic [4:0] ctl, input logic [1:0] st,
                            input logic [15:0] sc, input logic [15:0] fc);
        for (int i = 1; i <= 3; i++) push(i, tag, ctl, st, sc, fc);
    endtask

    task automatic observe(input int id, output logic [4:0] ctl, output logic [1:0] st,
                           output logic [15:0] sc, output logic [15:0] fc);
        case (id)
            1: begin
                ctl = {if1.PC_write, if1.IFID_write, if1.IFID_flush, if1.IDEX_bubble,
                       if1.pipe_freeze};
                st = if1.hz_state; sc = if1.stall_cnt; fc = if1.flush_cnt;
            end
            2: begin
                ctl = {if2.PC_write, if2.IFID_write, if2.IFID_flush, if2.IDEX_bubble,
                       if2.pipe_freeze};
                st = if2.hz_state; sc = if2.stall_cnt; fc = if2.flush_cnt;
            end
            default: begin
                ctl = {if3.PC_write, if3.IFID_write, if3.IFID_flush, if3.IDEX_bubble,
                       if3.pipe_freeze};
                st = if3.hz_state; sc = {12'd0, if3.stall_cnt}; fc = {12'd0, if3.flush_cnt};
            end
        endcase
    endtask

    task automatic cmp(input string tag, input int id, input string field,
                       input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d %s observed=%0h expected=%0h", tag, id, field, obs, exp);
        end
    endtask

    // Let combinational outputs settle, then retire every queued expectation.
    task automatic drain();
        exp_t        e;
        logic [4:0]  ctl;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] fc;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            observe(e.id, ctl, st, sc, fc);
            cmp(e.tag, e.id, "ctl", {11'd0, ctl}, {11'd0, e.ctl});
            cmp(e.tag, e.id, "hz_state", {14'd0, st}, {14'd0, e.st});
            cmp(e.tag, e.id, "stall_cnt", sc, e.sc);
            cmp(e.tag, e.id, "flush_cnt", fc, e.fc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        idle(1); idle(2); idle(3);

        // Reset held for three cycles.
        for (int k = 0; k < 3; k++) begin
            tick(); push_all("reset", CtlRst, 2'd0, 16'd0, 16'd0); drain();
        end
        tick(); rst_n = 1'b1;
        push_all("post_reset", CtlNorm, 2'd0, 16'd0, 16'd0); drain();

        // Single-bubble load-use (instance 1).
        tick(); hazard(1); push(1, "l1_hz", CtlStall, 2'd0, 16'd0, 16'd0); drain();
        tick(); idle(1); push(1, "l1_after", CtlNorm, 2'd0, 16'd1, 16'd0); drain();
        tick(); drive(1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        push(1, "l1_r0", CtlNorm, 2'd0, 16'd1, 16'd0); drain();
        tick(); drive(1, 5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        push(1, "l1_rt", CtlStall, 2'd0, 16'd1, 16'd0); drain();
        tick(); drive(1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        push(1, "l1_nouse", CtlNorm, 2'd0, 16'd2, 16'd0); drain();
        tick(); drive(1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        push(1, "l1_noload", CtlNorm, 2'd0, 16'd2, 16'd0); drain();
        tick(); idle(1); push(1, "l1_end", CtlNorm, 2'd0, 16'd2, 16'd0); drain();

        // Branch beats hazard, then two-bubble load-use (instance 2).
        tick(); drive(2, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        push(2, "br_hz", CtlFlush, 2'd0, 16'd0, 16'd0); drain();
        tick(); idle(2); push(2, "br_after", CtlNorm, 2'd0, 16'd0, 16'd1); drain();
        tick(); hazard(2); push(2, "l2_hz", CtlStall, 2'd0, 16'd0, 16'd1); drain();
        tick(); idle(2); push(2, "l2_b2", CtlStall, 2'd1, 16'd1, 16'd1); drain();
        tick(); idle(2); push(2, "l2_run", CtlNorm, 2'd0, 16'd2, 16'd1); drain();
        tick(); drive(2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        push(2, "l2_r0", CtlNorm, 2'd0, 16'd2, 16'd1); drain();

        // Freeze wins over branch; branch taken on release (instance 2).
        tick(); drive(2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        push(2, "fzbr_1", CtlFrz, 2'd0, 16'd2, 16'd1); drain();
        tick(); push(2, "fzbr_2", CtlFrz, 2'd2, 16'd2, 16'd1); drain();
        tick(); drive(2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        push(2, "fzbr_rel", CtlFlush, 2'd2, 16'd2, 16'd1); drain();
        tick(); idle(2); push(2, "fzbr_end", CtlNorm, 2'd0, 16'd2, 16'd2); drain();

        // Memory wait inside LSTALL with one bubble left (instance 3).
        tick(); hazard(3); push(3, "l3_hz", CtlStall, 2'd0, 16'd0, 16'd0); drain();
        tick(); idle(3); push(3, "l3_b2", CtlStall, 2'd1, 16'd1, 16'd0); drain();
        tick(); drive(3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        push(3, "mw_1", CtlFrz, 2'd1, 16'd2, 16'd0); drain();
        for (int k = 0; k < 3; k++) begin
            tick(); push(3, "mw_n", CtlFrz, 2'd2, 16'd2, 16'd0); drain();
        end
        tick(); drive(3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        push(3, "mw_rel", CtlStall, 2'd2, 16'd2, 16'd0); drain();
        tick(); idle(3); push(3, "mw_run", CtlNorm, 2'd0, 16'd3, 16'd0); drain();

        // Flush counter saturation with a 4-bit counter: 19 flushes.
        for (int i = 0; i < 19; i++) begin
            tick(); drive(3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
            push(3, "sat", CtlFlush, 2'd0, 16'd3, (i > 15) ? 16'd15 : 16'(i)); drain();
        end
        tick(); idle(3); push(3, "sat_hold", CtlNorm, 2'd0, 16'd3, 16'd15); drain();

        // Asynchronous reset in the middle of LSTALL.
        tick(); hazard(3); push(3, "rl_hz", CtlStall, 2'd0, 16'd3, 16'd15); drain();
        tick(); idle(3); push(3, "rl_ls", CtlStall, 2'd1, 16'd4, 16'd15); drain();
        #1; rst_n = 1'b0;
        push_all("mid_reset", CtlRst, 2'd0, 16'd0, 16'd0); drain();
        tick(); rst_n = 1'b1;
        push_all("re_run", CtlNorm, 2'd0, 16'd0, 16'd0); drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
